// File: rtl/lzc_pkg.sv
// rtl/lzc_pkg.sv - shared state encoding and default geometry for the LZC normalizer
package lzc_pkg;

  localparam int LZC_WIDTH = 8;
  localparam int LZC_WORD  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT_Z  = 2'd2,
    OUT     = 2'd3
  } lzc_state_e;

endpackage

// File: rtl/lzc_shl.sv
// rtl/lzc_shl.sv - combinational W-bit left shifter driven by an already-clamped amount
module lzc_shl #(
  parameter int W  = 32,
  parameter int SW = $clog2(W) + 1
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  dout
);

  // amt == W shifts everything out, giving the all-zero result
  assign dout = din << amt;

endmodule

// File: rtl/lzc_norm.sv
// rtl/lzc_norm.sv - collects MSB-first beats and left-normalizes them by the LZC zero count
module lzc_norm
  import lzc_pkg::*;
#(
  parameter int width = LZC_WIDTH,
  parameter int word  = LZC_WORD,
  localparam int W    = width * word,
  localparam int ZW   = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [width-1:0] data,
  input  logic          Ivalid,
  output logic          in_ready,
  input  logic [ZW-1:0] zeros,
  input  logic          Ovalid,
  output logic [W-1:0]  norm_data,
  output logic [ZW-1:0] norm_shift,
  output logic          all_zero,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int KW = $clog2(word + 1);

  lzc_state_e    state_q, state_d;
  logic [KW-1:0] k_q;
  logic [W-1:0]  buf_q, buf_d, shl_out;
  logic [ZW-1:0] shift_clamp;
  logic          capture, take_z, xfer;

  assign in_ready    = ((state_q == IDLE) || (state_q == COLLECT)) && (k_q < KW'(word));
  assign capture     = Ivalid && in_ready;
  assign take_z      = Ovalid && (state_q != OUT);
  assign xfer        = (state_q == OUT) && out_ready;
  assign shift_clamp = (zeros > ZW'(W)) ? ZW'(W) : zeros;

  // Buffer including the beat captured this cycle, so a same-cycle Ovalid sees it
  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < word; i++) begin
      if (capture && (k_q == KW'(i))) begin
        buf_d[W-1-i*width -: width] = data;
      end
    end
  end

  lzc_shl #(.W(W), .SW(ZW)) u_shl (
    .din  (buf_d),
    .amt  (shift_clamp),
    .dout (shl_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (take_z) begin
          state_d = OUT;
        end else if (capture) begin
          state_d = (k_q == KW'(word - 1)) ? WAIT_Z : COLLECT;
        end
      end
      WAIT_Z: begin
        if (Ovalid) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      k_q        <= '0;
      norm_data  <= '0;
      norm_shift <= '0;
      all_zero   <= 1'b0;
      out_valid  <= 1'b0;
    end else if (xfer) begin
      buf_q     <= '0;
      k_q       <= '0;
      out_valid <= 1'b0;
    end else if (take_z) begin
      buf_q      <= buf_d;
      k_q        <= k_q + KW'(capture);
      norm_data  <= shl_out;
      norm_shift <= shift_clamp;
      all_zero   <= (shift_clamp == ZW'(W));
      out_valid  <= 1'b1;
    end else if (capture) begin
      buf_q <= buf_d;
      k_q   <= k_q + KW'(1);
    end
  end

endmodule

// File: tb/tb_lzc_norm.sv
// tb/tb_lzc_norm.sv - self-checking bench for lzc_norm: vector table, corner sequences, random model
module tb_lzc_norm;

  localparam int WD = 8;
  localparam int WO = 4;
  localparam int W  = WD * WO;
  localparam int ZW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WD-1:0] data;
  logic          Ivalid;
  logic          in_ready;
  logic [ZW-1:0] zeros;
  logic          Ovalid;
  logic [W-1:0]  norm_data;
  logic [ZW-1:0] norm_shift;
  logic          all_zero;
  logic          out_valid;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  lzc_norm #(.width(WD), .word(WO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .Ivalid     (Ivalid),
    .in_ready   (in_ready),
    .zeros      (zeros),
    .Ovalid     (Ovalid),
    .norm_data  (norm_data),
    .norm_shift (norm_shift),
    .all_zero   (all_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][7:0] b;
    int              z;
    bit              same;
    logic [31:0]     ed;
    int              es;
    bit              ea;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Operand as an integer: beat i occupies byte (3-i) counting from the LSB
  function automatic longint operand(input int n, input logic [3:0][7:0] b);
    longint op = 0;
    for (int i = 0; i < n; i++) op = op + longint'(b[i]) * (longint'(1) << (8 * (3 - i)));
    return op;
  endfunction

  function automatic int lead_zeros(input longint op);
    for (int p = 31; p >= 0; p--) if (op[p]) return 31 - p;
    return 32;
  endfunction

  function automatic vec_t mk(input int n, input logic [31:0] bw, input int z, input bit same);
    vec_t v;
    longint op;
    v.n = n;
    for (int i = 0; i < 4; i++) v.b[i] = bw[31-8*i -: 8];
    v.z = z;
    v.same = same;
    op = operand(n, v.b);
    v.es = (z > 32) ? 32 : z;
    v.ed = (v.es >= 32) ? 32'h0 : 32'((op << v.es) & 64'hFFFF_FFFF);
    v.ea = (v.es == 32);
    return v;
  endfunction

  // Called one time unit after a rising edge; leaves the DUT back in IDLE
  task automatic run_op(input vec_t v, input int hold, input bit noise, input string nm);
    for (int i = 0; i < v.n; i++) begin
      chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
      data = v.b[i];
      Ivalid = 1'b1;
      if (v.same && i == v.n - 1) begin
        Ovalid = 1'b1;
        zeros = ZW'(v.z);
      end
      @(posedge clk); #1;
      Ivalid = 1'b0;
      Ovalid = 1'b0;
      if (!(v.same && i == v.n - 1)) chk({nm, ".early_valid"}, 64'(out_valid), 64'd0);
    end
    if (!(v.same && v.n > 0)) begin
      Ovalid = 1'b1;
      zeros = ZW'(v.z);
      @(posedge clk); #1;
      Ovalid = 1'b0;
    end
    chk({nm, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".norm_data"}, 64'(norm_data), 64'(v.ed));
    chk({nm, ".norm_shift"}, 64'(norm_shift), 64'(v.es));
    chk({nm, ".all_zero"}, 64'(all_zero), 64'(v.ea));
    for (int c = 0; c < hold; c++) begin
      if (noise) begin
        Ivalid = 1'b1;
        data = WD'($urandom);
        Ovalid = 1'b1;
        zeros = '0;
      end
      @(posedge clk); #1;
      chk({nm, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, ".hold_data"}, 64'(norm_data), 64'(v.ed));
      chk({nm, ".hold_shift"}, 64'(norm_shift), 64'(v.es));
      chk({nm, ".hold_az"}, 64'(all_zero), 64'(v.ea));
      chk({nm, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    Ivalid = 1'b0;
    Ovalid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, ".after_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".after_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t rv;
    logic [31:0] bw;
    int n, z;
    rst_n = 1'b0;
    data = '0;
    Ivalid = 1'b0;
    zeros = '0;
    Ovalid = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.norm_data", 64'(norm_data), 64'd0);
    chk("reset.norm_shift", 64'(norm_shift), 64'd0);
    chk("reset.all_zero", 64'(all_zero), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    tbl[0] = mk(4, 32'h00012345, 15, 1'b0);
    tbl[1] = mk(4, 32'h00000000, 32, 1'b0);
    tbl[2] = mk(2, 32'h00400000, 9, 1'b1);
    tbl[3] = mk(0, 32'h00000000, 40, 1'b0);
    tbl[4] = mk(0, 32'h00000000, 5, 1'b0);
    chk("vec0.model", 64'(tbl[0].ed), 64'h91A28000);
    chk("vec2.model", 64'(tbl[2].ed), 64'h80000000);
    for (int i = 0; i < 5; i++) run_op(tbl[i], 0, 1'b0, $sformatf("vec%0d", i));

    // Back-pressure with stray beats and zero strobes that must be dropped
    run_op(tbl[0], 5, 1'b1, "stall");
    run_op(mk(4, 32'h0F00AA55, 4, 1'b0), 0, 1'b0, "post_stall");

    // Reset after two beats discards the partial operand
    data = 8'hFF;
    Ivalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    Ivalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid.norm_data", 64'(norm_data), 64'd0);
    chk("rst_mid.norm_shift", 64'(norm_shift), 64'd0);
    chk("rst_mid.all_zero", 64'(all_zero), 64'd0);
    chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(tbl[0], 0, 1'b0, "after_rst");

    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 4);
      bw = $urandom;
      if ($urandom_range(0, 1) == 1) bw = bw >> $urandom_range(0, 31);
      rv = mk(n, bw, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) z = lead_zeros(operand(n, rv.b));
      else z = $urandom_range(0, 63);
      rv = mk(n, bw, z, (n > 0) && ($urandom_range(0, 1) == 1));
      run_op(rv, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
